dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the MEM stage of the pipelined ARM core: target end of the
//  MemWriteM/ALUResultM/WriteDataM -> ReadDataM interface. Word-addressed SRAM model with
//  WAIT_STATES programmable latency and a busy/ready handshake. Core stalls on MemBusyM.
//  Flags misaligned or out-of-range accesses instead of aliasing them.
// PARAMETERS
//  DEPTH_WORDS  64  number of 32-bit words; valid byte addresses 0 .. 4*DEPTH_WORDS-1
//  WAIT_STATES  2   extra cycles between accept and response (0..15)
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-low; 0 = reset asserted
//  MemReqM      in   1   access request from MEM stage; held with operands until MemReadyM
//  MemWriteM    in   1   1 = store, 0 = load; sampled with MemReqM
//  ALUResultM   in   32  byte address
//  WriteDataM   in   32  store data
//  ReadDataM    out  32  load data; valid in the MemReadyM cycle
//  MemReadyM    out  1   one-cycle pulse: access complete
//  MemBusyM     out  1   to hazard unit: stall F/D/E/M while 1
//  MemErrM      out  1   qualifies MemReadyM: access rejected (misaligned/out of range)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, wait counter=0, ReadDataM=0, MemReadyM=0, MemErrM=0,
//   captured address/data/write regs=0. Array contents are not reset.
//  FSM states: IDLE, WAIT, DONE.
//   IDLE: if MemReqM: latch addr/data/write/err into regs; counter<=WAIT_STATES-1;
//         next = WAIT if WAIT_STATES>0, else DONE. MemReqM is sampled only in IDLE.
//   WAIT: counter decrements each cycle; at counter==0 next=DONE.
//   DONE: MemReadyM=1 for exactly this cycle; next=IDLE unconditionally.
//  Latency: request accepted at edge N -> MemReadyM high in cycle N+WAIT_STATES+1.
//  MemBusyM = (state==IDLE & MemReqM) | (state==WAIT) | (state==DONE & 0) -> combinational;
//   deasserts in the DONE cycle so the core advances on the same edge it sees MemReadyM.
//  Error: err = (addr[1:0]!=0) | (addr[31:2] >= DEPTH_WORDS), computed at accept time.
//  Store: array written on the edge leaving DONE, only if !err. No partial/byte writes.
//  Load: ReadDataM registered = mem[addr[31:2]] at DONE entry; ReadDataM=0 if err.
//   ReadDataM holds its value after DONE until the next load completes.
//  Erroring access: still takes full latency, MemReadyM=1 with MemErrM=1, no array change.
//  MemErrM is 0 outside the DONE cycle.
//  Back-to-back: request still high in DONE cycle is ignored; a new request is accepted
//   no earlier than the cycle after DONE (one idle bubble minimum).
//  Operand changes while WAIT/DONE are ignored (latched copy used).
//  Load after store to same address returns the new data (store commits before next accept).
//  Reset mid-access: access aborted, pending store discarded, no MemReadyM pulse.
//  Address arithmetic: word index = addr[31:2], width clog2(DEPTH_WORDS); no wrap-around.
// TESTING
//  1. WAIT_STATES=2, store 0xDEADBEEF @0x10 then load @0x10 -> MemReadyM at cycle 3 each,
//     ReadDataM=0xDEADBEEF, MemErrM=0, MemBusyM high cycles 0-2 of each access.
//  2. Load @0x13 (misaligned) and @0x100 (DEPTH_WORDS=64) -> MemErrM=1 with MemReadyM,
//     ReadDataM=0; a store @0x100 leaves mem[0..63] unchanged.
//  3. WAIT_STATES=0, MemReqM held high across ops -> accept, DONE next cycle, one-cycle
//     MemReadyM per access, never two accepts of one request.
//  4. Change ALUResultM/WriteDataM mid-WAIT -> store lands at originally latched address/data.
//  5. Drop reset to 0 during WAIT of a store @0x20 -> outputs zero asynchronously; after
//     release load @0x20 returns previous contents, not the aborted store data.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the MEM stage. It is a word-addressed SRAM model
//   with a programmable response latency and a busy/ready handshake. Accesses
//   that are misaligned or out of range are flagged and rejected. They are not
//   aliased onto a valid word.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for MemReqM; the request is latched on the accept edge
//   WAIT  | latency down-counter runs; a load samples the array on the exit edge
//   DONE  | MemReadyM (and MemErrM) pulse; a store commits on the exit edge
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   asynchronous reset, active low
//   MemReqM     in   access request; held with its operands until MemReadyM
//   MemWriteM   in   1 = store, 0 = load
//   ALUResultM  in   byte address
//   WriteDataM  in   store data
//   ReadDataM   out  load data; holds until the next load completes
//   MemReadyM   out  one-cycle completion pulse
//   MemBusyM    out  stall request to the hazard unit (combinational)
//   MemErrM     out  qualifies MemReadyM: access rejected
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemReadyM,
  output logic        MemBusyM,
  output logic        MemErrM
);

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      data_q;
  logic             write_q;
  logic             err_q;
  logic [31:0]      rdata_q;
  logic [31:0]      mem [DEPTH_WORDS];

  logic [29:0]      word_in;
  logic [IDX_W-1:0] idx_in;
  logic             err_in;
  logic             accept;
  logic             ld_fire;
  logic [IDX_W-1:0] ld_idx;
  logic             ld_err;

  // The full 30-bit word index is compared so that high addresses never wrap
  // onto a valid word.
  assign word_in = ALUResultM[31:2];
  assign idx_in  = word_in[IDX_W-1:0];
  assign err_in  = (ALUResultM[1:0] != 2'b00) || (word_in >= 30'(DEPTH_WORDS));
  assign accept  = (state_q == ST_IDLE) && MemReqM;

  // A load samples the array on the edge that enters DONE. With zero wait
  // states that edge is the accept edge itself, so the live operands are used
  // because the latched copy is not yet valid.
  always_comb begin
    ld_fire = 1'b0;
    ld_idx  = idx_q;
    ld_err  = err_q;
    if (WAIT_STATES == 0) begin
      ld_fire = accept && !MemWriteM;
      ld_idx  = idx_in;
      ld_err  = err_in;
    end else begin
      ld_fire = (state_q == ST_WAIT) && (cnt_q == 4'd0) && !write_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (MemReqM) state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_DONE;
      ST_WAIT: if (cnt_q == 4'd0) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    MemReadyM = (state_q == ST_DONE);
    MemErrM   = (state_q == ST_DONE) && err_q;
    MemBusyM  = accept || (state_q == ST_WAIT);
    ReadDataM = rdata_q;
  end

  // Latched request, latency timer and read-data register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      data_q  <= 32'd0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      if (accept) begin
        idx_q   <= idx_in;
        data_q  <= WriteDataM;
        write_q <= MemWriteM;
        err_q   <= err_in;
        cnt_q   <= CNT_INIT;
      end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (ld_fire) rdata_q <= ld_err ? 32'd0 : mem[ld_idx];
    end
  end

  // The array is not reset. A reset during an access returns the FSM to IDLE,
  // so a pending store never reaches this write.
  always_ff @(posedge clk) begin
    if ((state_q == ST_DONE) && write_q && !err_q) mem[idx_q] <= data_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic        wr_i = 1'b0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] data_i = 32'd0;

  logic [31:0] rdata_a, rdata_b, rdata_m;
  logic        ready_a, ready_b, ready_m;
  logic        busy_a, busy_b, busy_m;
  logic        err_a, err_b, err_m;
  logic        sel = 1'b0;

  logic [31:0] model_mem [2][DEPTH];
  logic [31:0] last_rd [2];
  int          n_vec = 0;
  int          n_miscmp = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) u_dut_a (
    .clk(clk), .reset(rst_n), .MemReqM(req_a), .MemWriteM(wr_i),
    .ALUResultM(addr_i), .WriteDataM(data_i), .ReadDataM(rdata_a),
    .MemReadyM(ready_a), .MemBusyM(busy_a), .MemErrM(err_a)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut_b (
    .clk(clk), .reset(rst_n), .MemReqM(req_b), .MemWriteM(wr_i),
    .ALUResultM(addr_i), .WriteDataM(data_i), .ReadDataM(rdata_b),
    .MemReadyM(ready_b), .MemBusyM(busy_b), .MemErrM(err_b)
  );

  assign rdata_m = sel ? rdata_b : rdata_a;
  assign ready_m = sel ? ready_b : ready_a;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign err_m   = sel ? err_b   : err_a;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int ws_of(input logic s);
    return s ? 0 : 2;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0)      a = (32'($urandom_range(0, DEPTH-1)) << 2) | 32'($urandom_range(1, 3));
    else if (r == 1) a = 32'($urandom_range(DEPTH, 32'h3FFF_FFFF)) << 2;
    else             a = 32'($urandom_range(0, DEPTH-1)) << 2;
    return a;
  endfunction

  // One access on instance s (0: two wait states, 1: zero wait states).
  // Returns in the MemReadyM cycle; hold keeps MemReqM asserted afterwards.
  task automatic access(input logic s, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic scramble, input logic hold);
    int   c;
    int   idx;
    logic exp_err;
    @(negedge clk);
    sel    = s;
    wr_i   = wr;
    addr_i = a;
    data_i = d;
    if (s) req_b = 1'b1; else req_a = 1'b1;
    #1;
    check_val("no_ready_c0", ready_m, 1'b0);
    check_val("no_err_c0", err_m, 1'b0);
    exp_err = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    idx = int'(a >> 2);
    c = 0;
    while (!ready_m && c < 40) begin
      check_val("busy", busy_m, 1'b1);
      if (scramble && c == 1) begin
        addr_i = $urandom;
        data_i = $urandom;
      end
      @(negedge clk);
      #1;
      c++;
    end
    check_val("latency", c, ws_of(s) + 1);
    check_val("busy_done", busy_m, 1'b0);
    check_val("err", err_m, exp_err);
    if (!exp_err && wr) model_mem[s][idx] = d;
    if (!wr) begin
      if (exp_err) last_rd[s] = 32'd0;
      else         last_rd[s] = model_mem[s][idx];
    end
    check_val("rdata", rdata_m, last_rd[s]);
    if (!hold) begin
      if (s) req_b = 1'b0; else req_a = 1'b0;
    end
  endtask

  initial begin
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    #23;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check_val("rst_rdata", rdata_m, 32'd0);
      check_val("rst_ready", ready_m, 1'b0);
      check_val("rst_busy", busy_m, 1'b0);
      check_val("rst_err", err_m, 1'b0);
    end
    rst_n = 1'b1;

    // Fill both arrays; instance 1 keeps its request asserted throughout.
    for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) access(1'b1, 1'b1, 32'(i * 4), $urandom, 1'b0, 1'b1);
    req_b = 1'b0;

    // Store/load round trip
    access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0);
    access(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);

    // Rejected accesses and the address boundaries
    access(1'b0, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0);
    access(1'b0, 1'b0, 32'hFC, 32'h0, 1'b0, 1'b0);
    access(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0);
    access(1'b0, 1'b1, 32'h100, 32'h1234_5678, 1'b0, 1'b0);
    access(1'b0, 1'b1, 32'h0000_0102, 32'h5555_AAAA, 1'b0, 1'b0);
    access(1'b1, 1'b1, 32'h100, 32'h8765_4321, 1'b0, 1'b0);
    access(1'b1, 1'b0, 32'h101, 32'h0, 1'b0, 1'b0);

    // Operands changing during WAIT are ignored
    access(1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, 1'b1, 1'b0);
    access(1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);

    // Reset during the WAIT of a store aborts it
    access(1'b0, 1'b0, 32'h24, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    sel    = 1'b0;
    wr_i   = 1'b1;
    addr_i = 32'h20;
    data_i = ~model_mem[0][8];
    req_a  = 1'b1;
    @(negedge clk);
    #2;
    check_val("busy_wait", busy_m, 1'b1);
    rst_n = 1'b0;
    req_a = 1'b0;
    #1;
    check_val("arst_ready", ready_m, 1'b0);
    check_val("arst_busy", busy_m, 1'b0);
    check_val("arst_err", err_m, 1'b0);
    check_val("arst_rdata", rdata_m, 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check_val("abort_no_ready", ready_m, 1'b0);
    end
    access(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0);

    // Randomised traffic on both instances
    for (int i = 0; i < 80; i++)
      access(1'b0, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
             1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 60; i++)
      access(1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'b0,
             1'($urandom_range(0, 1)));
    req_b = 1'b0;

    // Read back every word of both arrays
    for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b0, 32'(i * 4), 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) access(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0, 1'b1);
    req_b = 1'b0;
    @(negedge clk);
    #1;
    check_val("final_no_ready", ready_m, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
